// File: rtl/ex_hazard_ctrl_if.sv
// ID-stage register-usage inputs and hazard/forwarding controls exchanged
// between the pipeline datapath (master) and the EX hazard controller (slave).
interface ex_hazard_ctrl_if #(
  parameter int XLEN_REG = 5
);
  logic                id_valid;
  logic [XLEN_REG-1:0] id_rs1;
  logic [XLEN_REG-1:0] id_rs2;
  logic                id_uses_rs1;
  logic                id_uses_rs2;
  logic [XLEN_REG-1:0] id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_multicycle;
  logic                ex_branch_taken;

  logic                stall_if_id;
  logic                flush_if_id;
  logic                bubble_ex;
  logic                ex_hold;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, id_multicycle, ex_branch_taken,
    input  stall_if_id, flush_if_id, bubble_ex, ex_hold, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_mem_read, id_multicycle, ex_branch_taken,
    output stall_if_id, flush_if_id, bubble_ex, ex_hold, fwd_a, fwd_b
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: shadows EX/MEM/WB register usage to drive
// operand forwarding, load-use stall, branch flush and multi-cycle hold.
module ex_hazard_ctrl #(
  parameter int MC_CYCLES = 4,
  parameter int XLEN_REG  = 5
) (
  input logic              clk,
  input logic              reset,
  ex_hazard_ctrl_if.slave  bus
);
  localparam int CW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES + 1) : 1;

  typedef struct packed {
    logic                valid;
    logic [XLEN_REG-1:0] rd;
    logic                reg_write;
    logic                mem_read;
    logic [XLEN_REG-1:0] rs1;
    logic [XLEN_REG-1:0] rs2;
    logic                uses_rs1;
    logic                uses_rs2;
  } entry_t;

  typedef enum logic {RUN, MC_HOLD} state_t;

  entry_t          e_q, m_q, w_q;
  entry_t          e_d, m_d, w_d;
  entry_t          id_ent;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic            stall, flush, bubble, hold;
  logic [1:0]      fa, fb;

  // Forward from the youngest writer; x0 is never a forwarding source.
  function automatic logic [1:0] fwd_sel(entry_t e, entry_t m, entry_t w,
                                         logic [XLEN_REG-1:0] rs, logic uses);
    logic [1:0] sel;
    sel = 2'b00;
    if (e.valid && uses) begin
      if (m.valid && m.reg_write && (m.rd != '0) && (m.rd == rs))
        sel = 2'b01;
      else if (w.valid && w.reg_write && (w.rd != '0) && (w.rd == rs))
        sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    id_ent = '0;
    if (bus.id_valid) begin
      id_ent.valid     = 1'b1;
      id_ent.rd        = bus.id_rd;
      id_ent.reg_write = bus.id_reg_write;
      id_ent.mem_read  = bus.id_mem_read;
      id_ent.rs1       = bus.id_rs1;
      id_ent.rs2       = bus.id_rs2;
      id_ent.uses_rs1  = bus.id_uses_rs1;
      id_ent.uses_rs2  = bus.id_uses_rs2;
    end
  end

  assign load_use = e_q.valid && e_q.mem_read && (e_q.rd != '0) && bus.id_valid &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == e_q.rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == e_q.rd)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    m_d     = e_q;
    w_d     = m_q;
    stall   = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    hold    = 1'b0;
    unique case (state_q)
      MC_HOLD: begin
        // EX keeps the long op; MEM drains with bubbles; branches are ignored.
        hold  = 1'b1;
        stall = 1'b1;
        m_d   = '0;
        if (cnt_q <= CW'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (bus.ex_branch_taken) begin
          flush  = 1'b1;
          bubble = 1'b1;
          e_d    = '0;
        end else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
          e_d    = '0;
        end else begin
          e_d = id_ent;
          if (bus.id_valid && bus.id_multicycle && (MC_CYCLES > 1)) begin
            state_d = MC_HOLD;
            cnt_d   = CW'(MC_CYCLES - 1);
          end
        end
      end
    endcase
  end

  always_comb begin
    fa = fwd_sel(e_q, m_q, w_q, e_q.rs1, e_q.uses_rs1);
    fb = fwd_sel(e_q, m_q, w_q, e_q.rs2, e_q.uses_rs2);
  end

  // Reset outranks everything, including a hold already in progress.
  always_comb begin
    bus.stall_if_id = stall  && !reset;
    bus.flush_if_id = flush  && !reset;
    bus.bubble_ex   = bubble && !reset;
    bus.ex_hold     = hold   && !reset;
    bus.fwd_a       = reset ? 2'b00 : fa;
    bus.fwd_b       = reset ? 2'b00 : fb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      e_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      m_q     <= m_d;
      w_q     <= w_d;
    end
  end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: hand-computed control/forwarding vectors.
module tb_ex_hazard_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_hazard_ctrl_if #(.XLEN_REG(5)) bus();

  ex_hazard_ctrl #(.MC_CYCLES(4), .XLEN_REG(5)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive ID fields at the falling edge, check settled outputs 1ns later.
  // exp = {stall_if_id, flush_if_id, bubble_ex, ex_hold, fwd_a, fwd_b}
  task automatic step(input string tag, input logic v,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mc,
                      input logic br, input logic [7:0] exp);
    logic [7:0] obs;
    @(negedge clk);
    bus.id_valid        = v;
    bus.id_rs1          = rs1;
    bus.id_rs2          = rs2;
    bus.id_uses_rs1     = u1;
    bus.id_uses_rs2     = u2;
    bus.id_rd           = rd;
    bus.id_reg_write    = rw;
    bus.id_mem_read     = mr;
    bus.id_multicycle   = mc;
    bus.ex_branch_taken = br;
    #1;
    obs = {bus.stall_if_id, bus.flush_if_id, bus.bubble_ex, bus.ex_hold,
           bus.fwd_a, bus.fwd_b};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b (stall,flush,bubble,hold,fa,fb)",
             tag, obs, exp);
    end
  endtask

  task automatic nop(input string tag, input logic [7:0] exp);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    nop("reset_a", 8'b0000_0000);
    nop("reset_b", 8'b0000_0000);
    rst = 1'b0;
    nop("post_reset", 8'b0000_0000);

    // lw x5 ; add x6,x5,x7 -> one stall, then MEM/WB forward on A only
    step("lu_ld",     1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 8'b0000_0000);
    step("lu_stall",  1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 8'b1010_0000);
    step("lu_bubble", 1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, 0, 8'b0000_0000);
    nop("lu_fwd_w", 8'b0000_1000);

    // add x3 ; sub x3 ; or x4,x3,x3 -> EX/MEM wins over MEM/WB
    step("b_add3",  1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 8'b0000_0000);
    step("b_sub3",  1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 8'b0000_0000);
    step("b_or4",   1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 8'b0000_0000);
    nop("b_fwd_m", 8'b0000_0101);
    // add x3 ; and x9 ; or x4,x3,x3 -> only the older writer, from MEM/WB
    step("b_add3b", 1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 8'b0000_0000);
    step("b_and9",  1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0, 8'b0000_0000);
    step("b_or4b",  1, 5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 8'b0000_0000);
    nop("b_fwd_w", 8'b0000_1010);

    // lw x0 ; or x8,x0,x0 -> no stall, no forward
    step("c_ld_x0", 1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 8'b0000_0000);
    step("c_rd_x0", 1, 5'd0, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0, 8'b0000_0000);
    nop("c_no_fwd", 8'b0000_0000);

    // taken branch beats a pending load-use; EX must then be empty
    step("d_ld", 1, 5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 8'b0000_0000);
    step("d_br", 1, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 1, 8'b0110_0000);
    nop("d_e_empty", 8'b0000_0000);

    // mul x10,x10,x2 multi-cycle: 3 hold cycles, branch in hold ignored
    step("e_issue", 1, 5'd10, 5'd2, 1, 1, 5'd10, 1, 0, 1, 0, 8'b0000_0000);
    step("e_hold1", 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0, 0, 8'b1001_0000);
    step("e_hold2", 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0, 1, 8'b1001_0000);
    step("e_hold3", 1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0, 0, 8'b1001_0000);
    step("e_run",   1, 5'd10, 5'd0, 1, 0, 5'd11, 1, 0, 0, 0, 8'b0000_0000);
    nop("e_fwd", 8'b0000_0100);

    // reset on the 2nd hold cycle, then a fresh load-use behaves normally
    step("f_issue", 1, 5'd1, 5'd2, 1, 1, 5'd12, 1, 0, 1, 0, 8'b0000_0000);
    nop("f_hold1", 8'b1001_0000);
    rst = 1'b1;
    nop("f_rst", 8'b0000_0000);
    rst = 1'b0;
    step("f_after", 1, 5'd1,  5'd0,  1, 0, 5'd14, 1, 1, 0, 0, 8'b0000_0000);
    step("f_lu",    1, 5'd14, 5'd14, 1, 1, 5'd15, 1, 0, 0, 0, 8'b1010_0000);
    nop("f_end", 8'b0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
